// File: rtl/tqvp_reg_arbiter.sv
// tqvp_reg_arbiter: round-robin sharing of one TinyQV peripheral register port between two requesters.
// Define TQVP_ARB_TIMEOUT_EN to abort reads that wait longer than TIMEOUT_CYCLES.
module tqvp_reg_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_start,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [1:0]        req0_write_n,
  input  logic [1:0]        req0_read_n,
  output logic              req0_ack,
  output logic              req0_err,
  input  logic              req1_start,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [1:0]        req1_write_n,
  input  logic [1:0]        req1_read_n,
  output logic              req1_ack,
  output logic              req1_err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic [1:0]        data_write_n,
  output logic [1:0]        data_read_n,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_ready
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
  state_t state, state_n;
  logic [1:0] pend, pend_n, start, wcode, wcode_n, rcode, rcode_n, sel_w, sel_r;
  logic last, last_n, gnt, gnt_n, err_q, err_n, sel, tmo;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n, rdata_n, masked;
`ifdef TQVP_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt;
  assign tmo = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (state == READ) ? cnt + 1'b1 : '0;
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  // a requester's start is ignored while it is pending or being served, but accepted in its ack cycle
  assign start[0] = req0_start && !pend[0] && !((state == WRITE || state == READ) && !gnt);
  assign start[1] = req1_start && !pend[1] && !((state == WRITE || state == READ) && gnt);
  assign sel = (pend == 2'b11) ? ~last : pend[1];
  assign sel_w = sel ? req1_write_n : req0_write_n;
  assign sel_r = sel ? req1_read_n : req0_read_n;
  assign masked = rcode == 2'b00 ? {{(DATA_W-8){1'b0}}, data_out[7:0]} :
                  rcode == 2'b01 ? {{(DATA_W-16){1'b0}}, data_out[15:0]} : data_out;
  always_comb begin
    state_n = state;
    pend_n = pend | start;
    last_n = last;
    gnt_n = gnt;
    err_n = err_q;
    wcode_n = wcode;
    rcode_n = rcode;
    addr_n = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata;
    case (state)
      IDLE: if (|pend) begin
        pend_n[sel] = 1'b0;
        gnt_n = sel;
        last_n = sel;
        addr_n = sel ? req1_addr : req0_addr;
        wdata_n = sel ? req1_wdata : req0_wdata;
        wcode_n = sel_w;
        rcode_n = sel_r;
        rdata_n = '0;
        err_n = (sel_w == 2'b11) == (sel_r == 2'b11);
        state_n = err_n ? RESP : (sel_w != 2'b11 ? WRITE : READ);
      end
      WRITE: state_n = RESP;
      READ: if (data_ready) begin
        rdata_n = masked;
        state_n = RESP;
      end else if (tmo) begin
        err_n = 1'b1;
        state_n = RESP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pend <= '0;
      last <= 1'b1;
      gnt <= 1'b0;
      err_q <= 1'b0;
      wcode <= 2'b11;
      rcode <= 2'b11;
      addr_q <= '0;
      wdata_q <= '0;
      rdata <= '0;
    end else begin
      state <= state_n;
      pend <= pend_n;
      last <= last_n;
      gnt <= gnt_n;
      err_q <= err_n;
      wcode <= wcode_n;
      rcode <= rcode_n;
      addr_q <= addr_n;
      wdata_q <= wdata_n;
      rdata <= rdata_n;
    end
  assign busy = state != IDLE;
  assign address = addr_q;
  assign data_in = wdata_q;
  assign data_write_n = state == WRITE ? wcode : 2'b11;
  assign data_read_n = state == READ ? rcode : 2'b11;
  assign req0_ack = state == RESP && !gnt;
  assign req1_ack = state == RESP && gnt;
  assign req0_err = req0_ack && err_q;
  assign req1_err = req1_ack && err_q;
endmodule
